// File: rtl/avl_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// avl_cfg_arbiter
//
// Two-requester round-robin arbiter in front of one Avalon-MM config master
// port. s0 is the LUT-driven transceiver-config sequencer and s1 is the
// runtime status/poll engine. Only one transaction is in flight at a time.
//
// Handshake (requester side): a requester raises sN_read_req or
// sN_write_req together with address/writedata and holds all of them steady
// while sN_busy is high. The single cycle in which sN_busy is low is the
// completion cycle; sN_readdata is valid in that cycle only. If both read
// and write are raised together, the write is issued and the read ignored.
// Master side: avl_*_req is held until a cycle with avl_busy low.
//
// Optional feature: define AVL_ARB_TIMEOUT_EN to abort a granted transfer
// after TIMEOUT_CYCLES consecutive avl_busy cycles. The aborted requester
// sees one busy-low cycle with ABORT_DATA on its readdata and timeout_err
// becomes sticky high until reset.
//
// Ports:
//   clock, reset_n               clock, asynchronous active-low reset
//   sN_read_req / sN_write_req   requester N read / write request
//   sN_address / sN_writedata    requester N address / write data
//   sN_readdata / sN_busy        read data and wait signal to requester N
//   avl_read_req/avl_write_req   master read / write
//   avl_address / avl_writedata  master address / write data
//   avl_readdata / avl_busy      slave read data / waitrequest
//   timeout_err                  sticky abort flag (0 without timeout feature)
//   fsm_state                    current arbiter state, for debug/checkers
// ---------------------------------------------------------------------------
module avl_cfg_arbiter #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ABORT_DATA     = 32'hDEADBEEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              s0_read_req,
    input  logic              s0_write_req,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_busy,
    input  logic              s1_read_req,
    input  logic              s1_write_req,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_busy,
    output logic              avl_read_req,
    output logic              avl_write_req,
    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_busy,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
    } state_t;

    state_t state, state_nxt;
    logic   sel, sel_nxt;                // granted requester
    logic   last_grant, last_grant_nxt;  // requester that last completed
    logic   abort;                       // timeout abort in this cycle

    logic              s0_active, s1_active;
    logic              g_read, g_write, g_active;
    logic [ADDR_W-1:0] g_address;
    logic [DATA_W-1:0] g_writedata;

    assign s0_active = s0_read_req | s0_write_req;
    assign s1_active = s1_read_req | s1_write_req;

    // Signals of the granted requester, muxed on the registered select.
    assign g_read      = sel ? s1_read_req  : s0_read_req;
    assign g_write     = sel ? s1_write_req : s0_write_req;
    assign g_address   = sel ? s1_address   : s0_address;
    assign g_writedata = sel ? s1_writedata : s0_writedata;
    assign g_active    = g_read | g_write;

    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;  // s0 wins the first tie
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        avl_read_req   = 1'b0;
        avl_write_req  = 1'b0;
        avl_address    = '0;
        avl_writedata  = '0;
        s0_busy        = 1'b1;
        s1_busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                if (s0_active && s1_active) begin
                    sel_nxt   = ~last_grant;
                    state_nxt = ST_GRANT;
                end else if (s0_active) begin
                    sel_nxt   = 1'b0;
                    state_nxt = ST_GRANT;
                end else if (s1_active) begin
                    sel_nxt   = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (abort) begin
                    // Master request withdrawn; requester released with abort data.
                    if (sel) s1_busy = 1'b0;
                    else     s0_busy = 1'b0;
                    last_grant_nxt = sel;
                    state_nxt      = ST_IDLE;
                end else begin
                    avl_write_req = g_write;
                    avl_read_req  = g_read & ~g_write;  // write wins over read
                    avl_address   = g_address;
                    avl_writedata = g_writedata;
                    if (sel) s1_busy = avl_busy;
                    else     s0_busy = avl_busy;
                    if (!g_active) begin
                        // Request withdrawn mid-transfer: no completion, no fairness update.
                        state_nxt = ST_IDLE;
                    end else if (!avl_busy) begin
                        last_grant_nxt = sel;
                        state_nxt      = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef AVL_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic             timeout_err_q;

    assign abort = (state == ST_GRANT) && (timer == TMR_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_GRANT) begin
                timer <= '0;
            end else if (state == ST_GRANT && avl_busy && !abort) begin
                timer <= timer + 1'b1;
            end
            if (abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
    assign s0_readdata = (abort && !sel) ? ABORT_DATA : avl_readdata;
    assign s1_readdata = (abort &&  sel) ? ABORT_DATA : avl_readdata;
`else
    // Timeout parameters are only meaningful with the timeout feature.
    logic unused_cfg;
    assign unused_cfg  = ^{ABORT_DATA, TIMEOUT_CYCLES[0]};

    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
    assign s0_readdata = avl_readdata;
    assign s1_readdata = avl_readdata;
`endif

endmodule
